// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and default widths for the memory arbiter.
//   state_t : arbiter FSM states (IDLE, ISSUE, WAIT_RD)
//   gnt_t   : one-hot grant encoding (GNT_NONE, GNT_IC, GNT_DC)
//   *_DEF   : default parameter values used by mem_arbiter
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF  = 32;
  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned TIMEOUT_DEF = 255;
  localparam int unsigned WE_W        = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_IC   = 2'b01,
    GNT_DC   = 2'b10
  } gnt_t;

  // The requester that should be preferred after g has been served.
  function automatic gnt_t other_gnt(input gnt_t g);
    return (g == GNT_IC) ? GNT_DC : GNT_IC;
  endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// mem_arb_grant: combinational two-way grant selection.
//   ic_valid : icache request valid
//   dc_valid : dcache request valid
//   prio     : requester that wins a tie (GNT_IC or GNT_DC)
//   gnt      : one-hot grant, GNT_NONE when nothing is requested
module mem_arb_grant
  import mem_arb_pkg::*;
(
  input  logic ic_valid,
  input  logic dc_valid,
  input  gnt_t prio,
  output gnt_t gnt
);

  // A lone requester always wins; a tie goes to prio (dcache unless prio says icache).
  always_comb begin
    gnt = GNT_NONE;
    if (ic_valid && dc_valid) begin
      gnt = (prio == GNT_IC) ? GNT_IC : GNT_DC;
    end else if (dc_valid) begin
      gnt = GNT_DC;
    end else if (ic_valid) begin
      gnt = GNT_IC;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates icache and dcache requests onto a single memory
// port with one outstanding transaction at a time.
//   clk, reset          : clock and synchronous active-high reset
//   ic_req_*            : icache read request (valid/addr) and ready
//   ic_resp_valid       : one-cycle pulse, resp_data holds icache read data
//   dc_req_*            : dcache request (valid/addr/we/wdata) and ready
//   dc_resp_valid       : one-cycle pulse, read data or write ack for dcache
//   resp_data           : read data shared by both response pulses
//   mem_req_*           : memory request channel (valid/ready/addr/we/wdata)
//   mem_resp_valid/data : memory read data return
//   err                 : sticky read-timeout flag, cleared only by reset
// Build option: define MEM_ARB_ROUND_ROBIN_EN to alternate tie winners;
// otherwise the dcache always wins a tie.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_req_valid,
  input  logic [ADDR_W-1:0] ic_req_addr,
  output logic              ic_req_ready,
  output logic              ic_resp_valid,
  input  logic              dc_req_valid,
  input  logic [ADDR_W-1:0] dc_req_addr,
  input  logic [WE_W-1:0]   dc_req_we,
  input  logic [DATA_W-1:0] dc_req_wdata,
  output logic              dc_req_ready,
  output logic              dc_resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [WE_W-1:0]   mem_req_we,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  output logic              err
);

  // Counter runs 0..TIMEOUT-1; the last value is the final WAIT_RD cycle.
  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  gnt_t             prio;
  gnt_t             owner;
  gnt_t             gnt;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  mem_arb_grant u_grant (
    .ic_valid (ic_req_valid),
    .dc_valid (dc_req_valid),
    .prio     (prio),
    .gnt      (gnt)
  );

  // Ready is combinational so a request is accepted in the cycle it is seen.
  assign accept       = !reset && (state == IDLE) && (gnt != GNT_NONE);
  assign ic_req_ready = accept && (gnt == GNT_IC);
  assign dc_req_ready = accept && (gnt == GNT_DC);

  // Arbiter FSM with registered memory fields and response pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      prio          <= GNT_DC;
      owner         <= GNT_NONE;
      cnt           <= '0;
      ic_resp_valid <= 1'b0;
      dc_resp_valid <= 1'b0;
      resp_data     <= '0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_we    <= '0;
      mem_req_wdata <= '0;
      err           <= 1'b0;
    end else begin
      ic_resp_valid <= 1'b0;
      dc_resp_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (accept) begin
            owner         <= gnt;
            mem_req_valid <= 1'b1;
            if (gnt == GNT_DC) begin
              mem_req_addr  <= dc_req_addr;
              mem_req_we    <= dc_req_we;
              mem_req_wdata <= dc_req_wdata;
            end else begin
              // icache only ever reads
              mem_req_addr  <= ic_req_addr;
              mem_req_we    <= '0;
              mem_req_wdata <= '0;
            end
`ifdef MEM_ARB_ROUND_ROBIN_EN
            prio <= other_gnt(gnt);
`endif
            state <= ISSUE;
          end
        end

        ISSUE: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            cnt           <= '0;
            if (mem_req_we != '0) begin
              // writes complete on handshake; only the dcache issues them
              dc_resp_valid <= (owner == GNT_DC);
              ic_resp_valid <= (owner == GNT_IC);
              state         <= IDLE;
            end else begin
              state <= WAIT_RD;
            end
          end
        end

        WAIT_RD: begin
          // A response in the last counted cycle still wins over the timeout.
          if (mem_resp_valid) begin
            resp_data     <= mem_resp_data;
            ic_resp_valid <= (owner == GNT_IC);
            dc_resp_valid <= (owner == GNT_DC);
            state         <= IDLE;
          end else if (cnt == CNT_LAST) begin
            err           <= 1'b1;
            resp_data     <= '0;
            ic_resp_valid <= (owner == GNT_IC);
            dc_resp_valid <= (owner == GNT_DC);
            state         <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized transactions against a
// transaction-level model of the arbiter (grant choice, field capture,
// response timing, timeout and sticky error).
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          ic_req_valid;
  logic [AW-1:0] ic_req_addr;
  logic          ic_req_ready;
  logic          ic_resp_valid;
  logic          dc_req_valid;
  logic [AW-1:0] dc_req_addr;
  logic [3:0]    dc_req_we;
  logic [DW-1:0] dc_req_wdata;
  logic          dc_req_ready;
  logic          dc_resp_valid;
  logic [DW-1:0] resp_data;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [AW-1:0] mem_req_addr;
  logic [3:0]    mem_req_we;
  logic [DW-1:0] mem_req_wdata;
  logic          mem_resp_valid;
  logic [DW-1:0] mem_resp_data;
  logic          err;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk            (clk),
    .reset          (reset),
    .ic_req_valid   (ic_req_valid),
    .ic_req_addr    (ic_req_addr),
    .ic_req_ready   (ic_req_ready),
    .ic_resp_valid  (ic_resp_valid),
    .dc_req_valid   (dc_req_valid),
    .dc_req_addr    (dc_req_addr),
    .dc_req_we      (dc_req_we),
    .dc_req_wdata   (dc_req_wdata),
    .dc_req_ready   (dc_req_ready),
    .dc_resp_valid  (dc_resp_valid),
    .resp_data      (resp_data),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_req_we     (mem_req_we),
    .mem_req_wdata  (mem_req_wdata),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .err            (err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model state: who was granted last, and the expected sticky error.
  bit last_dc = 1'b0;
  bit err_exp = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns 1 when the dcache should win given the current valids.
  function automatic bit pick_dc(input bit ic_v, input bit dc_v);
    if (ic_v && dc_v) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      return !last_dc;
`else
      return 1'b1;
`endif
    end
    return dc_v;
  endfunction

  // One full transaction starting in IDLE: accept, ISSUE with `stall` refused
  // cycles, then for reads a response after `delay` WAIT_RD cycles (>= TO: none).
  task automatic do_txn(input bit ic_v, input bit dc_v,
                        input logic [31:0] ic_a, input logic [31:0] dc_a,
                        input logic [3:0] we, input logic [31:0] wd,
                        input int stall, input int delay, input logic [31:0] rdata);
    bit          g_dc;
    bit          is_wr;
    bit          got;
    logic [31:0] ea;
    logic [3:0]  ewe;
    logic [31:0] exp_data;

    g_dc  = pick_dc(ic_v, dc_v);
    ea    = g_dc ? dc_a : ic_a;
    ewe   = g_dc ? we : 4'h0;
    is_wr = (ewe != 4'h0);

    ic_req_valid = ic_v;  ic_req_addr  = ic_a;
    dc_req_valid = dc_v;  dc_req_addr  = dc_a;
    dc_req_we    = we;    dc_req_wdata = wd;
    #1;
    chk("ic_ready_accept", 64'(ic_req_ready), 64'(!g_dc));
    chk("dc_ready_accept", 64'(dc_req_ready), 64'(g_dc));
    chk("mem_valid_idle", 64'(mem_req_valid), 64'(0));
    last_dc = g_dc;
    tick();

    // Loser and winner both drop; scramble the request fields.
    ic_req_valid = 1'b0; dc_req_valid = 1'b0;
    ic_req_addr  = $urandom; dc_req_addr = $urandom;
    dc_req_we    = 4'($urandom); dc_req_wdata = $urandom;

    for (int s = 0; s <= stall; s++) begin
      mem_req_ready  = (s == stall);
      mem_resp_valid = (s != stall) && 1'($urandom_range(0, 1));
      mem_resp_data  = $urandom;
      ic_req_valid   = 1'($urandom_range(0, 1));
      dc_req_valid   = 1'($urandom_range(0, 1));
      #1;
      chk("issue_mem_valid", 64'(mem_req_valid), 64'(1));
      chk("issue_addr", 64'(mem_req_addr), 64'(ea));
      chk("issue_we", 64'(mem_req_we), 64'(ewe));
      if (g_dc) chk("issue_wdata", 64'(mem_req_wdata), 64'(wd));
      chk("issue_readies", 64'({ic_req_ready, dc_req_ready}), 64'(0));
      chk("issue_resp", 64'({ic_resp_valid, dc_resp_valid}), 64'(0));
      tick();
    end
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    ic_req_valid  = 1'b0; dc_req_valid   = 1'b0;

    if (is_wr) begin
      #1;
      chk("wr_ack_dc", 64'(dc_resp_valid), 64'(1));
      chk("wr_ack_ic", 64'(ic_resp_valid), 64'(0));
      chk("wr_mem_valid_drop", 64'(mem_req_valid), 64'(0));
    end else begin
      got = 1'b0;
      for (int k = 0; k < int'(TO) && !got; k++) begin
        mem_resp_valid = (k == delay);
        mem_resp_data  = rdata;
        ic_req_valid   = 1'($urandom_range(0, 1));
        dc_req_valid   = 1'($urandom_range(0, 1));
        #1;
        chk("wait_readies", 64'({ic_req_ready, dc_req_ready}), 64'(0));
        chk("wait_resp", 64'({ic_resp_valid, dc_resp_valid}), 64'(0));
        chk("wait_mem_valid", 64'(mem_req_valid), 64'(0));
        if (k == delay) got = 1'b1;
        tick();
      end
      mem_resp_valid = 1'b0;
      ic_req_valid   = 1'b0; dc_req_valid = 1'b0;
      #1;
      exp_data = got ? rdata : 32'h0;
      if (!got) err_exp = 1'b1;
      chk("rd_resp_ic", 64'(ic_resp_valid), 64'(!g_dc));
      chk("rd_resp_dc", 64'(dc_resp_valid), 64'(g_dc));
      chk("rd_resp_data", 64'(resp_data), 64'(exp_data));
    end
    chk("err_flag", 64'(err), 64'(err_exp));
    tick();
    chk("resp_pulse_end", 64'({ic_resp_valid, dc_resp_valid}), 64'(0));
    chk("err_flag_hold", 64'(err), 64'(err_exp));
  endtask

  initial begin
    reset = 1'b1;
    ic_req_valid = 1'b0; ic_req_addr = '0;
    dc_req_valid = 1'b0; dc_req_addr = '0; dc_req_we = '0; dc_req_wdata = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    repeat (3) tick();
    chk("rst_readies", 64'({ic_req_ready, dc_req_ready}), 64'(0));
    chk("rst_resp", 64'({ic_resp_valid, dc_resp_valid}), 64'(0));
    chk("rst_resp_data", 64'(resp_data), 64'(0));
    chk("rst_mem_valid", 64'(mem_req_valid), 64'(0));
    chk("rst_mem_addr", 64'(mem_req_addr), 64'(0));
    chk("rst_mem_we", 64'(mem_req_we), 64'(0));
    chk("rst_mem_wdata", 64'(mem_req_wdata), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    reset = 1'b0;
    last_dc = 1'b0; err_exp = 1'b0;
    tick();

    // Two back-to-back ties straight out of reset.
    do_txn(1, 1, 32'h0000_1000, 32'h0000_2000, 4'h0, 32'h0, 0, 0, 32'hA5A5_0001);
    do_txn(1, 1, 32'h0000_1004, 32'h0000_2004, 4'h0, 32'h0, 0, 0, 32'hA5A5_0002);

    // dcache read, response two cycles after the handshake cycle.
    do_txn(0, 1, 32'h0, 32'h0000_0100, 4'h0, 32'h0, 0, 1, 32'hDEAD_BEEF);

    // dcache write held off by memory for three cycles.
    do_txn(0, 1, 32'h0, 32'h0000_0200, 4'hF, 32'h1234_5678, 3, 0, 32'h0);

    // Response arriving in the same cycle as the timeout wins.
    do_txn(1, 0, 32'h0000_0300, 32'h0, 4'h0, 32'h0, 1, int'(TO) - 1, 32'hCAFE_F00D);
    chk("coincident_no_err", 64'(err), 64'(0));

    // Read with no response: timeout, zero data, sticky error.
    do_txn(0, 1, 32'h0, 32'h0000_0400, 4'h0, 32'h0, 0, 100, 32'h0);

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      bit          iv, dv;
      logic [3:0]  w;
      iv = 1'($urandom_range(0, 1));
      dv = 1'($urandom_range(0, 1));
      if (!iv && !dv) dv = 1'b1;
      w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      do_txn(iv, dv, $urandom, $urandom, w, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 9), $urandom);
    end

    // Reset while a read is waiting; the late response must be ignored.
    dc_req_valid = 1'b1; dc_req_addr = 32'h0000_0500; dc_req_we = 4'h0;
    #1;
    chk("mid_accept", 64'(dc_req_ready), 64'(1));
    tick();
    dc_req_valid = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = 32'h5555_AAAA;
    #1;
    chk("mid_rst_resp", 64'({ic_resp_valid, dc_resp_valid}), 64'(0));
    chk("mid_rst_err", 64'(err), 64'(0));
    chk("mid_rst_mem_valid", 64'(mem_req_valid), 64'(0));
    chk("mid_rst_data", 64'(resp_data), 64'(0));
    tick();
    mem_resp_valid = 1'b0;
    chk("mid_rst_resp2", 64'({ic_resp_valid, dc_resp_valid}), 64'(0));
    chk("mid_rst_resp_data2", 64'(resp_data), 64'(0));
    last_dc = 1'b0; err_exp = 1'b0;

    // IDLE after reset: a tie is accepted immediately and goes to the dcache.
    do_txn(1, 1, 32'h0000_0600, 32'h0000_0700, 4'h0, 32'h0, 0, 2, 32'h0BAD_CAFE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Pulses must never overlap.
  always @(negedge clk) begin
    if (!reset && ic_resp_valid && dc_resp_valid) begin
      checks++;
      errors++;
      $error("FAIL resp_exclusive observed=both expected=at_most_one");
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
